// File: rtl/rf_pkg.sv
// Register-file shared types: address/data widths and the writeback request record.
package rf_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  typedef struct packed {
    rf_addr_t rd;
    rf_data_t data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at ptr, ptr moves past the winner on advance.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   ptr
);
  localparam logic [PTR_W:0] N_W = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] nxt_ptr;
  logic [PTR_W:0]   sum;
  logic [PTR_W:0]   inc;
  logic             found;

  // ptr holds the highest-priority source, i.e. last winner + 1
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= N_W) sum = sum - N_W;
      if (!found && valid[sum[PTR_W-1:0]]) begin
        grant[sum[PTR_W-1:0]] = 1'b1;
        gnt_idx               = sum[PTR_W-1:0];
        found                 = 1'b1;
      end
    end
    inc = {1'b0, gnt_idx} + (PTR_W+1)'(1);
    if (inc >= N_W) inc = '0;
    nxt_ptr = inc[PTR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= nxt_ptr;
    end
  end
endmodule

// File: rtl/rf_wb_sched.sv
// Writeback scheduler for the register file write port plus a pending-write scoreboard
// that lets issue logic stall on RAW/WAW hazards.
module rf_wb_sched
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ADDR_W-1:0]              rf_rd,
  output logic                           rf_write_e,
  output logic [DATA_W-1:0]              rf_write_d,
  input  logic                           issue_valid,
  input  logic [ADDR_W-1:0]              issue_rd,
  output logic                           issue_ready,
  input  logic [ADDR_W-1:0]              chk_rs1,
  input  logic [ADDR_W-1:0]              chk_rs2,
  output logic                           hazard
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   rr_ptr;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_rd;
  logic [DATA_W-1:0]  sel_data;
  logic [DEPTH-1:0]   pending;
  logic [DEPTH-1:0]   pending_nxt;
  logic               set_en;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .advance (xfer),
    .grant   (grant),
    .ptr     (rr_ptr)
  );

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);

  // grant is one-hot, so an OR-reduction mux is sufficient
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = sel_rd | req_rd[i];
        sel_data = sel_data | req_data[i];
      end
    end
  end

  assign issue_ready = issue_valid && ((issue_rd == '0) || !pending[issue_rd]);
  assign set_en      = issue_ready && (issue_rd != '0);
  assign hazard      = pending[chk_rs1] || pending[chk_rs2];

  // Clear lands on the same edge the rf commits; x0 is never tracked
  always_comb begin
    pending_nxt = pending;
    if (rf_write_e) pending_nxt[rf_rd] = 1'b0;
    if (set_en) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_e <= 1'b0;
      rf_rd      <= '0;
      rf_write_d <= '0;
    end else begin
      rf_write_e <= xfer && (sel_rd != '0);
      if (xfer) begin
        rf_rd      <= sel_rd;
        rf_write_d <= sel_data;
      end
    end
  end

  a_no_set_clr_same: assert property (@(posedge clk) disable iff (!rst_n)
    !(set_en && rf_write_e && (issue_rd == rf_rd)));

  a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n)
    int'(rr_ptr) < NUM_REQ);
endmodule
